// File: rtl/sti_cmd_sched.sv
// rtl/sti_cmd_sched.sv - descriptor FIFO and load/burst/gap scheduler for the STI_DAC datapath
module sti_cmd_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [15:0]                  cmd_data,
    input  logic [1:0]                   cmd_length,
    input  logic                         cmd_fill,
    input  logic                         cmd_msb,
    input  logic                         cmd_low,
    input  logic                         cmd_end,
    output logic                         load,
    output logic [15:0]                  pi_data,
    output logic [1:0]                   pi_length,
    output logic                         pi_fill,
    output logic                         pi_msb,
    output logic                         pi_low,
    output logic                         pi_end,
    input  logic                         so_valid,
    output logic                         sched_busy,
    output logic                         sched_finish,
    output logic                         sched_err,
    output logic [1:0]                   err_code,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                   words_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_XFER,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  length;
        logic        fill;
        logic        msb;
        logic        low;
        logic        last;
    } desc_t;

    desc_t          mem_q [FIFO_DEPTH];
    desc_t          hold_q;
    desc_t          cmd_desc;
    state_t         state_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic [WW-1:0]  wait_q;
    logic [GW-1:0]  gap_q;
    logic [5:0]     bits_q;
    logic [5:0]     bits_inc;
    logic [5:0]     exp_bits;
    logic [7:0]     words_q;
    logic [1:0]     err_code_q;
    logic           load_q;
    logic           push;
    logic           pop;
    logic           accepting;

    assign cmd_desc  = {cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low, cmd_end};
    assign accepting = (state_q != S_DONE) && (state_q != S_ERR);
    assign cmd_ready = (level_q != LEVEL_FULL) && accepting;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (level_q != '0);

    // 8 * (length + 1): 8, 16, 24 or 32 bits per descriptor.
    assign exp_bits  = {({1'b0, hold_q.length} + 3'd1), 3'b000};
    assign bits_inc  = bits_q + 6'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // load is the registered image of the LOAD state, so it lands one cycle after LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            load_q     <= 1'b0;
            wait_q     <= '0;
            gap_q      <= '0;
            bits_q     <= '0;
            words_q    <= '0;
            err_code_q <= 2'b00;
        end else begin
            load_q <= (state_q == S_LOAD);
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        hold_q  <= mem_q[rd_ptr_q];
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wait_q  <= '0;
                    bits_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    wait_q <= wait_q + WW'(1);
                    if (so_valid) begin
                        bits_q <= 6'd1;
                        if (exp_bits == 6'd1) begin
                            gap_q   <= '0;
                            words_q <= words_q + 8'd1;
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_XFER;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        err_code_q <= 2'b01;
                        state_q    <= S_ERR;
                    end
                end
                S_XFER: begin
                    if (so_valid) begin
                        bits_q <= bits_inc;
                        if (bits_inc == exp_bits) begin
                            gap_q   <= '0;
                            words_q <= words_q + 8'd1;
                            state_q <= S_GAP;
                        end
                    end else begin
                        err_code_q <= 2'b10;
                        state_q    <= S_ERR;
                    end
                end
                S_GAP: begin
                    if (so_valid) begin
                        err_code_q <= 2'b11;
                        state_q    <= S_ERR;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= hold_q.last ? S_DONE : S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                S_DONE:  state_q <= S_DONE;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    assign load         = load_q;
    assign pi_data      = hold_q.data;
    assign pi_length    = hold_q.length;
    assign pi_fill      = hold_q.fill;
    assign pi_msb       = hold_q.msb;
    assign pi_low       = hold_q.low;
    assign pi_end       = hold_q.last;
    assign sched_busy   = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                          (state_q == S_XFER) || (state_q == S_GAP);
    assign sched_finish = (state_q == S_DONE);
    assign sched_err    = (state_q == S_ERR);
    assign err_code     = err_code_q;
    assign fifo_level   = level_q;
    assign words_sent   = words_q;

endmodule

// File: tb/tb_sti_cmd_sched.sv
// tb/tb_sti_cmd_sched.sv - table and scoreboard bench for sti_cmd_sched
module tb_sti_cmd_sched;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
    localparam int GAP_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_length;
    logic        cmd_fill;
    logic        cmd_msb;
    logic        cmd_low;
    logic        cmd_end;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        so_valid;
    logic        sched_busy;
    logic        sched_finish;
    logic        sched_err;
    logic [1:0]  err_code;
    logic [2:0]  fifo_level;
    logic [7:0]  words_sent;

    sti_cmd_sched #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT(TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_length(cmd_length), .cmd_fill(cmd_fill), .cmd_msb(cmd_msb),
        .cmd_low(cmd_low), .cmd_end(cmd_end),
        .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_valid(so_valid), .sched_busy(sched_busy), .sched_finish(sched_finish),
        .sched_err(sched_err), .err_code(err_code), .fifo_level(fifo_level),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  len;
        logic        fill;
        logic        low;
        logic        end_f;
    } desc_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  len;
        int          nbits;
        bit          ovr;
        logic [1:0]  code;
        logic [7:0]  words;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          load_cnt = 0;
    desc_t       sb_q[$];
    bit          in_xfer = 1'b0;
    logic [15:0] held_data;
    logic [1:0]  held_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each load pulse pops the oldest accepted descriptor.
    always @(negedge clk) begin
        if (reset) begin
            in_xfer = 1'b0;
        end else if (load) begin
            load_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_load got pi_data %0h expected no load", pi_data);
            end else begin
                desc_t e;
                e = sb_q.pop_front();
                chk("sb_data", pi_data, e.data);
                chk("sb_len", pi_length, e.len);
                chk("sb_flags", {pi_fill, pi_msb, pi_low, pi_end}, {e.fill, 1'b1, e.low, e.end_f});
            end
            in_xfer   = 1'b1;
            held_data = pi_data;
            held_len  = pi_length;
        end else if (in_xfer) begin
            if (!sched_busy) begin
                in_xfer = 1'b0;
            end else begin
                chk("pi_stable", {pi_data, pi_length}, {held_data, held_len});
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        so_valid  = 1'b0;
        tick();
        reset = 1'b0;
        sb_q.delete();
        load_cnt = 0;
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] l, input logic e, output bit acc);
        cmd_data   = d;
        cmd_length = l;
        cmd_end    = e;
        cmd_fill   = d[0];
        cmd_low    = d[1];
        cmd_msb    = 1'b1;
        cmd_valid  = 1'b1;
        acc        = cmd_ready;
        if (acc) sb_q.push_back({d, l, d[0], d[1], e});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        while (!load && n < 60) begin
            tick();
            n++;
        end
        if (!load) chk("wait_load_timeout", load, 1'b1);
    endtask

    // Entered in the load cycle; bits start two cycles later.
    task automatic drive_bits(input int nbits, input bit ovr);
        tick();
        tick();
        for (int i = 0; i < nbits; i++) begin
            so_valid = 1'b1;
            tick();
        end
        so_valid = 1'b0;
        if (ovr) begin
            so_valid = 1'b1;
            tick();
            so_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        bit   acc;
        bit   accs [5];
        int   n;
        int   lc;
        logic [1:0] lens [4];

        vecs[0] = '{16'hA5C3, 2'd0, 8,  1'b0, 2'd0, 8'd1};
        vecs[1] = '{16'h1234, 2'd1, 16, 1'b0, 2'd0, 8'd1};
        vecs[2] = '{16'hBEEF, 2'd2, 24, 1'b0, 2'd0, 8'd1};
        vecs[3] = '{16'hCAFE, 2'd3, 32, 1'b0, 2'd0, 8'd1};
        vecs[4] = '{16'h0F0F, 2'd3, 0,  1'b0, 2'd1, 8'd0};
        vecs[5] = '{16'h5555, 2'd1, 10, 1'b0, 2'd2, 8'd0};
        vecs[6] = '{16'hAAAA, 2'd0, 8,  1'b1, 2'd3, 8'd1};
        vecs[7] = '{16'h7E81, 2'd2, 5,  1'b0, 2'd2, 8'd0};

        reset = 1'b1; cmd_valid = 1'b0; so_valid = 1'b0;
        cmd_data = '0; cmd_length = '0; cmd_fill = 0; cmd_msb = 0; cmd_low = 0; cmd_end = 0;
        tick();
        tick();
        chk("rst_load", load, 0);
        chk("rst_pi", {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}, 0);
        chk("rst_status", {sched_busy, sched_finish, sched_err, err_code}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_words", words_sent, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_reset();
            push(vecs[i].data, vecs[i].len, 1'b0, acc);
            chk("vec_accept", acc, 1);
            chk("lat_e0", load, 0);
            tick();
            chk("lat_e1", load, 0);
            tick();
            chk("lat_e2", load, 1);
            if (vecs[i].code == 2'd1) begin
                repeat (TIMEOUT - 1) tick();
                chk("timeout_early", sched_err, 0);
                tick();
                chk("timeout_at", sched_err, 1);
            end else begin
                drive_bits(vecs[i].nbits, vecs[i].ovr);
                if (vecs[i].code == 2'd2) begin
                    chk("short_pre", sched_err, 0);
                    tick();
                    chk("short_at", err_code, 2'd2);
                end
                repeat (GAP_CYCLES) tick();
            end
            chk("vec_err", sched_err, (vecs[i].code != 2'd0));
            chk("vec_code", err_code, vecs[i].code);
            chk("vec_words", words_sent, vecs[i].words);
            chk("vec_busy", sched_busy, 0);
            chk("vec_ready", cmd_ready, (vecs[i].code == 2'd0));
            chk("vec_finish", sched_finish, 0);
            chk("vec_one_load", load_cnt, 1);
        end

        // FIFO fill while the first descriptor waits for its burst
        do_reset();
        lens = '{2'd1, 2'd2, 2'd3, 2'd1};
        push(16'h1111, 2'd0, 1'b0, acc);
        wait_load(n);
        for (int k = 0; k < 5; k++) begin
            push(16'h2000 + 16'(k), (k < 4) ? lens[k] : 2'd0, 1'b0, acc);
            accs[k] = acc;
        end
        for (int k = 0; k < 5; k++) chk("full_accept", accs[k], (k < 4));
        chk("full_level", fifo_level, 3'd4);
        chk("full_ready", cmd_ready, 0);
        drive_bits(8, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_load(n);
            chk("gap_idle", (n >= GAP_CYCLES), 1);
            drive_bits(8 * (int'(lens[k]) + 1), 1'b0);
        end
        repeat (GAP_CYCLES) tick();
        chk("full_words", words_sent, 8'd5);
        chk("full_loads", load_cnt, 5);
        chk("full_sb_empty", sb_q.size(), 0);
        chk("full_err", sched_err, 0);

        // end-of-session descriptor
        do_reset();
        push(16'h3001, 2'd0, 1'b0, acc);
        push(16'h3002, 2'd0, 1'b1, acc);
        wait_load(n);
        drive_bits(8, 1'b0);
        wait_load(n);
        drive_bits(8, 1'b0);
        repeat (GAP_CYCLES) tick();
        chk("done_finish", sched_finish, 1);
        chk("done_ready", cmd_ready, 0);
        chk("done_words", words_sent, 8'd2);
        chk("done_busy", sched_busy, 0);
        push(16'hDEAD, 2'd0, 1'b0, acc);
        chk("done_ignore", acc, 0);
        repeat (4) tick();
        chk("done_sticky", sched_finish, 1);
        chk("done_level", fifo_level, 0);
        chk("done_loads", load_cnt, 2);

        // reset in the middle of a 32-bit burst
        do_reset();
        push(16'hC0DE, 2'd3, 1'b0, acc);
        push(16'hBAD0, 2'd0, 1'b0, acc);
        wait_load(n);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            so_valid = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_load", load, 0);
        chk("mid_rst_pi", {pi_data, pi_length, pi_end}, 0);
        chk("mid_rst_status", {sched_busy, sched_finish, sched_err, err_code}, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_words", words_sent, 0);
        reset    = 1'b0;
        so_valid = 1'b0;
        sb_q.delete();
        lc = load_cnt;
        repeat (5) tick();
        chk("mid_rst_noload", load_cnt, lc);
        push(16'h0E0E, 2'd0, 1'b0, acc);
        wait_load(n);
        drive_bits(8, 1'b0);
        repeat (GAP_CYCLES) tick();
        chk("post_rst_words", words_sent, 8'd1);
        chk("post_rst_err", sched_err, 0);
        chk("post_rst_busy", sched_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
